game_sequencer: RTL

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_if.sv | 29 ++
 rtl/game_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - control/status bundle between game sequencer and game datapath
interface game_sequencer_if;
  // controls and flags into the sequencer
  logic       start_btn;
  logic       pause_btn;
  logic       frame_tick;
  logic       lossA;
  logic       lossB;
  logic       wall_col;
  // sequencer outputs to the datapath and status observers
  logic       game_en;
  logic       round_rst_n;
  logic       gmv;
  logic [2:0] state;
  logic [1:0] winner;
  logic [7:0] round_cnt;

  // side that drives buttons, frame ticks and collision flags
  modport master (
    output start_btn, pause_btn, frame_tick, lossA, lossB, wall_col,
    input  game_en, round_rst_n, gmv, state, winner, round_cnt
  );

  // the sequencer itself
  modport slave (
    input  start_btn, pause_btn, frame_tick, lossA, lossB, wall_col,
    output game_en, round_rst_n, gmv, state, winner, round_cnt
  );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - match/serve/play/over sequencer; optional pause state via GAME_SEQUENCER_PAUSE_EN
module game_sequencer #(
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input  logic           clk,
  input  logic           rst_n,
  game_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] SERVE = 3'd2;
  localparam logic [2:0] PLAY  = 3'd3;
  localparam logic [2:0] PAUSE = 3'd4;
  localparam logic [2:0] OVER  = 3'd5;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES);
  localparam logic [7:0] ROUND_MAX  = 8'd255;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [2:0] resume_q;
  logic [7:0] serve_cnt;
  logic [7:0] over_cnt;
  logic [7:0] round_cnt_q;
  logic [1:0] winner_q;
  logic       play_pulse;

  logic       start_q;
  logic       pause_q;
  logic       wall_q;
  // armed stays low for the first cycle after reset so a level already high
  // at release is absorbed into the edge registers instead of reading as an edge
  logic       armed;

  logic       start_edge;
  logic       pause_edge;
  logic       wall_edge;
  logic       loss_any;

  assign start_edge = armed & bus.start_btn & ~start_q;
  assign wall_edge  = armed & bus.wall_col  & ~wall_q;
  assign loss_any   = bus.lossA | bus.lossB;

`ifdef GAME_SEQUENCER_PAUSE_EN
  assign pause_edge = armed & bus.pause_btn & ~pause_q;
`else
  logic unused_pause;
  assign pause_edge   = 1'b0;
  assign unused_pause = pause_q;
`endif

  // edge-detect registers for the button and wall-collision levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      pause_q <= 1'b0;
      wall_q  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      start_q <= bus.start_btn;
      pause_q <= bus.pause_btn;
      wall_q  <= bus.wall_col;
      armed   <= 1'b1;
    end
  end

  // next-state selection; PLAY exits ordered loss, point, pause
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_edge) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = SERVE;
      end
      SERVE: begin
        if (pause_edge)
          state_d = PAUSE;
        else if (bus.frame_tick && (serve_cnt == SERVE_LAST))
          state_d = PLAY;
      end
      PLAY: begin
        if (loss_any)
          state_d = OVER;
        else if (wall_edge)
          state_d = SERVE;
        else if (pause_edge)
          state_d = PAUSE;
      end
      PAUSE: begin
        if (pause_edge) state_d = resume_q;
      end
      OVER: begin
        if (start_edge && (over_cnt == OVER_LAST)) state_d = CLEAR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state register plus the state to return to when leaving PAUSE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      resume_q <= IDLE;
    end else begin
      state_q <= state_d;
      if ((state_d == PAUSE) && (state_q != PAUSE)) resume_q <= state_q;
    end
  end

  // serve hold-off counter: counts frames in SERVE, cleared on release into PLAY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      serve_cnt <= 8'd0;
    end else if (state_q == CLEAR) begin
      serve_cnt <= 8'd0;
    end else if (state_q == SERVE) begin
      if (state_d == PLAY)
        serve_cnt <= 8'd0;
      else if ((state_d == SERVE) && bus.frame_tick)
        serve_cnt <= serve_cnt + 8'd1;
    end
  end

  // game-over dwell counter: restarts on OVER entry, saturates at OVER_FRAMES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      over_cnt <= 8'd0;
    end else if ((state_d == OVER) && (state_q != OVER)) begin
      over_cnt <= 8'd0;
    end else if ((state_q == OVER) && bus.frame_tick && (over_cnt != OVER_LAST)) begin
      over_cnt <= over_cnt + 8'd1;
    end
  end

  // points-played counter and winner capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_cnt_q <= 8'd0;
      winner_q    <= 2'b00;
    end else if (state_q == CLEAR) begin
      round_cnt_q <= 8'd0;
      winner_q    <= 2'b00;
    end else if (state_q == PLAY) begin
      if (state_d == OVER)
        winner_q <= {bus.lossA, bus.lossB};
      else if ((state_d == SERVE) && (round_cnt_q != ROUND_MAX))
        round_cnt_q <= round_cnt_q + 8'd1;
    end
  end

  // one-cycle datapath step after each frame tick that keeps the game in PLAY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      play_pulse <= 1'b0;
    else
      play_pulse <= (state_q == PLAY) && (state_d == PLAY) && bus.frame_tick;
  end

  // outputs decode from reset-cleared registers, so reset drops them at once
  assign bus.game_en     = (state_q == CLEAR) | play_pulse;
  assign bus.round_rst_n = (state_q == SERVE) | (state_q == PLAY) |
                           (state_q == PAUSE) | (state_q == OVER);
  assign bus.gmv         = (state_q == CLEAR);
  assign bus.state       = state_q;
  assign bus.winner      = winner_q;
  assign bus.round_cnt   = round_cnt_q;

endmodule
